// File: rtl/ne16_package.sv
// Shared types and constants for the NE16 scale-lanes block.
package ne16_package;

    localparam int unsigned NE16_SCALE_LANES_DEPTH = 2;
    localparam int unsigned SHIFT_SEL_W            = 4;

    typedef struct packed {
        logic [SHIFT_SEL_W-1:0] shift_sel;
        logic                   invert;
        logic                   signed_mode;
        logic                   sat_en;
    } ctrl_scale_lanes_t;

    typedef struct packed {
        logic [SHIFT_SEL_W-1:0] shift_sel;
        logic [1:0]             count;
        logic                   sat_seen;
    } flags_scale_lanes_t;

endpackage

// File: rtl/ne16_scale_lane.sv
// One combinational scale lane: extend, shift, optional negate, then clamp or wrap.
module ne16_scale_lane
    import ne16_package::*;
#(
    parameter int unsigned INP_ACC  = 8,
    parameter int unsigned OUT_ACC  = 16,
    parameter int unsigned N_SHIFTS = 8
) (
    input  logic [INP_ACC-1:0] data_i,
    input  logic               enable_i,
    input  ctrl_scale_lanes_t  ctrl_i,
    output logic [OUT_ACC-1:0] data_o,
    output logic               sat_o
);

    // Wide enough that neither the shift nor the negation can lose bits.
    localparam int unsigned EXT_W = OUT_ACC + N_SHIFTS + 1;

    localparam logic signed [EXT_W-1:0] S_MAX = {{(EXT_W-OUT_ACC+1){1'b0}}, {(OUT_ACC-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] S_MIN = {{(EXT_W-OUT_ACC+1){1'b1}}, {(OUT_ACC-1){1'b0}}};
    localparam logic signed [EXT_W-1:0] U_MAX = {{(EXT_W-OUT_ACC){1'b0}}, {OUT_ACC{1'b1}}};
    localparam logic [SHIFT_SEL_W:0]    N_SH  = (SHIFT_SEL_W+1)'(N_SHIFTS);

    logic signed [EXT_W-1:0]  ext;
    logic signed [EXT_W-1:0]  shifted;
    logic signed [EXT_W-1:0]  res;
    logic [SHIFT_SEL_W-1:0]   shift_amt;
    logic                     range_signed;
    logic                     over_hi;
    logic                     under_lo;
    logic [OUT_ACC-1:0]       clamp_val;

    always_comb begin
        shift_amt = ({1'b0, ctrl_i.shift_sel} < N_SH) ? ctrl_i.shift_sel : '0;

        if (ctrl_i.signed_mode) begin
            ext = {{(EXT_W-INP_ACC){data_i[INP_ACC-1]}}, data_i};
        end else begin
            ext = {{(EXT_W-INP_ACC){1'b0}}, data_i};
        end

        shifted = ext <<< shift_amt;
        res     = ctrl_i.invert ? -shifted : shifted;

        range_signed = ctrl_i.signed_mode | ctrl_i.invert;
        over_hi      = range_signed ? (res > S_MAX) : (res > U_MAX);
        under_lo     = range_signed ? (res < S_MIN) : res[EXT_W-1];

        if (range_signed) begin
            clamp_val = under_lo ? {1'b1, {(OUT_ACC-1){1'b0}}} : {1'b0, {(OUT_ACC-1){1'b1}}};
        end else begin
            clamp_val = under_lo ? '0 : '1;
        end

        data_o = '0;
        sat_o  = 1'b0;
        if (enable_i) begin
            data_o = (ctrl_i.sat_en && (over_hi || under_lo)) ? clamp_val : res[OUT_ACC-1:0];
            sat_o  = over_hi | under_lo;
        end
    end

endmodule

// File: rtl/ne16_scale_lanes.sv
// N parallel scale lanes feeding a 2-entry skid FIFO with sticky saturation flag.
module ne16_scale_lanes
    import ne16_package::*;
#(
    parameter int unsigned N_LANES  = 16,
    parameter int unsigned INP_ACC  = 8,
    parameter int unsigned OUT_ACC  = 16,
    parameter int unsigned N_SHIFTS = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            test_mode_i,
    input  logic                            clear_i,
    input  logic                            data_i_valid,
    output logic                            data_i_ready,
    input  logic [N_LANES*INP_ACC-1:0]      data_i_data,
    input  logic [N_LANES*INP_ACC/8-1:0]    data_i_strb,
    output logic                            data_o_valid,
    input  logic                            data_o_ready,
    output logic [N_LANES*OUT_ACC-1:0]      data_o_data,
    output logic [N_LANES*OUT_ACC/8-1:0]    data_o_strb,
    input  ctrl_scale_lanes_t               ctrl_i,
    output flags_scale_lanes_t              flags_o
);

    localparam int unsigned IN_BYTES   = INP_ACC / 8;
    localparam int unsigned OUT_BYTES  = OUT_ACC / 8;
    localparam int unsigned DATA_W     = N_LANES * OUT_ACC;
    localparam int unsigned STRB_W     = N_LANES * OUT_BYTES;

    logic unused_test_mode;
    assign unused_test_mode = test_mode_i;

    logic [DATA_W-1:0]  lane_data;
    logic [STRB_W-1:0]  lane_strb;
    logic [N_LANES-1:0] lane_sat;

    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        logic lane_en;
        assign lane_en = &data_i_strb[l*IN_BYTES +: IN_BYTES];
        assign lane_strb[l*OUT_BYTES +: OUT_BYTES] = {OUT_BYTES{lane_en}};

        ne16_scale_lane #(
            .INP_ACC  (INP_ACC),
            .OUT_ACC  (OUT_ACC),
            .N_SHIFTS (N_SHIFTS)
        ) u_lane (
            .data_i   (data_i_data[l*INP_ACC +: INP_ACC]),
            .enable_i (lane_en),
            .ctrl_i   (ctrl_i),
            .data_o   (lane_data[l*OUT_ACC +: OUT_ACC]),
            .sat_o    (lane_sat[l])
        );
    end

    logic [DATA_W-1:0]      mem_data_q  [NE16_SCALE_LANES_DEPTH];
    logic [STRB_W-1:0]      mem_strb_q  [NE16_SCALE_LANES_DEPTH];
    logic [SHIFT_SEL_W-1:0] mem_shift_q [NE16_SCALE_LANES_DEPTH];

    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] count_q, count_d;
    logic       sat_seen_q, sat_seen_d;
    logic       push, pop;

    // Ready depends only on registered count, never on data_o_ready.
    assign data_i_ready = (count_q < 2'(NE16_SCALE_LANES_DEPTH));
    assign data_o_valid = (count_q != 2'd0);
    assign push         = data_i_valid & data_i_ready & ~clear_i;
    assign pop          = data_o_valid & data_o_ready & ~clear_i;

    always_comb begin
        count_d    = count_q;
        sat_seen_d = sat_seen_q;
        if (clear_i) begin
            count_d    = 2'd0;
            sat_seen_d = 1'b0;
        end else begin
            if (push && !pop) begin
                count_d = count_q + 2'd1;
            end else if (!push && pop) begin
                count_d = count_q - 2'd1;
            end
            if (push && (|lane_sat)) begin
                sat_seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q    <= 2'd0;
            sat_seen_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            count_q    <= count_d;
            sat_seen_q <= sat_seen_d;
            if (clear_i) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= ~wr_ptr_q;
                if (pop)  rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Payload storage is not reset; count/pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data_q[wr_ptr_q]  <= lane_data;
            mem_strb_q[wr_ptr_q]  <= lane_strb;
            mem_shift_q[wr_ptr_q] <= ctrl_i.shift_sel;
        end
    end

    assign data_o_data       = mem_data_q[rd_ptr_q];
    assign data_o_strb       = mem_strb_q[rd_ptr_q];
    assign flags_o.shift_sel = data_o_valid ? mem_shift_q[rd_ptr_q] : ctrl_i.shift_sel;
    assign flags_o.count     = count_q;
    assign flags_o.sat_seen  = sat_seen_q;

endmodule

// File: tb/tb_ne16_scale_lanes.sv
// Scoreboard bench for ne16_scale_lanes: a 16-lane 8->16 instance and a 2-lane 8->8 instance.
module tb_ne16_scale_lanes;
    import ne16_package::*;

    logic clk;
    logic rst_ni;
    logic clear_i;
    logic test_mode;

    logic               data_i_valid, data_i_ready;
    logic [127:0]       data_i_data;
    logic [15:0]        data_i_strb;
    logic               data_o_valid, data_o_ready;
    logic [255:0]       data_o_data;
    logic [31:0]        data_o_strb;
    ctrl_scale_lanes_t  ctrl;
    flags_scale_lanes_t flags;

    logic               in8_valid, in8_ready;
    logic [15:0]        in8_data;
    logic [1:0]         in8_strb;
    logic               out8_valid, out8_ready;
    logic [15:0]        out8_data;
    logic [1:0]         out8_strb;
    ctrl_scale_lanes_t  ctrl8;
    flags_scale_lanes_t flags8;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  s;
    } exp_t;
    exp_t sb[$];
    exp_t sb8[$];

    ne16_scale_lanes #(
        .N_LANES (16), .INP_ACC (8), .OUT_ACC (16), .N_SHIFTS (8)
    ) dut (
        .clk_i (clk), .rst_ni (rst_ni), .test_mode_i (test_mode), .clear_i (clear_i),
        .data_i_valid (data_i_valid), .data_i_ready (data_i_ready),
        .data_i_data (data_i_data), .data_i_strb (data_i_strb),
        .data_o_valid (data_o_valid), .data_o_ready (data_o_ready),
        .data_o_data (data_o_data), .data_o_strb (data_o_strb),
        .ctrl_i (ctrl), .flags_o (flags)
    );

    ne16_scale_lanes #(
        .N_LANES (2), .INP_ACC (8), .OUT_ACC (8), .N_SHIFTS (8)
    ) dut8 (
        .clk_i (clk), .rst_ni (rst_ni), .test_mode_i (test_mode), .clear_i (clear_i),
        .data_i_valid (in8_valid), .data_i_ready (in8_ready),
        .data_i_data (in8_data), .data_i_strb (in8_strb),
        .data_o_valid (out8_valid), .data_o_ready (out8_ready),
        .data_o_data (out8_data), .data_o_strb (out8_strb),
        .ctrl_i (ctrl8), .flags_o (flags8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic ctrl_scale_lanes_t mk_ctrl(input logic [3:0] sh, input logic inv,
                                                  input logic sgn, input logic sat);
        ctrl_scale_lanes_t c;
        c.shift_sel   = sh;
        c.invert      = inv;
        c.signed_mode = sgn;
        c.sat_en      = sat;
        return c;
    endfunction

    function automatic logic [255:0] rep_data(input logic [15:0] v, input logic [15:0] en);
        logic [255:0] r;
        r = '0;
        for (int l = 0; l < 16; l++) r[l*16 +: 16] = en[l] ? v : 16'h0;
        return r;
    endfunction

    function automatic logic [31:0] rep_strb(input logic [15:0] en);
        logic [31:0] r;
        r = '0;
        for (int l = 0; l < 16; l++) r[l*2 +: 2] = en[l] ? 2'b11 : 2'b00;
        return r;
    endfunction

    // Called just after a falling edge; returns on the falling edge after the handshake.
    task automatic send(input logic [7:0] v, input logic [15:0] en, input ctrl_scale_lanes_t c,
                        input logic [15:0] exp_v);
        exp_t e;
        data_i_data  = {16{v}};
        data_i_strb  = en;
        ctrl         = c;
        data_i_valid = 1'b1;
        e.d = rep_data(exp_v, en);
        e.s = rep_strb(en);
        for (int i = 0; i < 50; i++) begin
            if (data_i_ready) begin
                sb.push_back(e);
                @(negedge clk);
                data_i_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        tests++;
        fails++;
        $display("FAIL send_timeout: got ready=0, expected ready=1 within 50 cycles");
        data_i_valid = 1'b0;
    endtask

    task automatic send8(input logic [7:0] v, input ctrl_scale_lanes_t c, input logic [7:0] exp_v);
        exp_t e;
        in8_data  = {2{v}};
        in8_strb  = 2'b11;
        ctrl8     = c;
        in8_valid = 1'b1;
        e.d = 256'({2{exp_v}});
        e.s = 32'(2'b11);
        for (int i = 0; i < 50; i++) begin
            if (in8_ready) begin
                sb8.push_back(e);
                @(negedge clk);
                in8_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        tests++;
        fails++;
        $display("FAIL send8_timeout: got ready=0, expected ready=1 within 50 cycles");
        in8_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0 && sb8.size() == 0 && !data_o_valid && !out8_valid) return;
            @(negedge clk);
        end
        tests++;
        fails++;
        $display("FAIL drain_timeout: got %0d/%0d pending beats, expected 0", sb.size(), sb8.size());
    endtask

    initial begin : monitor_main
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (data_o_valid && data_o_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got %0h, expected no beat", data_o_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data", data_o_data, e.d);
                    check("out_strb", 256'(data_o_strb), 256'(e.s));
                end
            end
        end
    end

    initial begin : monitor_8
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (out8_valid && out8_ready) begin
                if (sb8.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat8: got %0h, expected no beat", out8_data);
                end else begin
                    e = sb8.pop_front();
                    check("out8_data", 256'(out8_data), e.d);
                    check("out8_strb", 256'(out8_strb), 256'(e.s));
                end
            end
        end
    end

    initial begin : stimulus
        logic [255:0] head_a;
        rst_ni = 1'b0;
        clear_i = 1'b0;
        test_mode = 1'b0;
        data_i_valid = 1'b0;
        data_i_data = '0;
        data_i_strb = '0;
        data_o_ready = 1'b1;
        ctrl = mk_ctrl(4'd5, 1'b0, 1'b0, 1'b0);
        in8_valid = 1'b0;
        in8_data = '0;
        in8_strb = '0;
        out8_ready = 1'b1;
        ctrl8 = mk_ctrl(4'd0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        #1;
        check("rst_valid", 256'(data_o_valid), 256'(1'b0));
        check("rst_ready", 256'(data_i_ready), 256'(1'b1));
        check("rst_count", 256'(flags.count), 256'(2'd0));
        check("rst_sat_seen", 256'(flags.sat_seen), 256'(1'b0));
        check("empty_shift_sel", 256'(flags.shift_sel), 256'(4'd5));
        @(negedge clk);

        // Basic scaling and 1-cycle latency.
        send(8'h7F, 16'hFFFF, mk_ctrl(4'd3, 1'b0, 1'b0, 1'b0), 16'h03F8);
        #1;
        check("latency_valid", 256'(data_o_valid), 256'(1'b1));
        check("latency_count", 256'(flags.count), 256'(2'd1));
        @(negedge clk);
        check("v1_sat_seen", 256'(flags.sat_seen), 256'(1'b0));

        // Back-to-back streaming patterns.
        send(8'h80, 16'hFFFF, mk_ctrl(4'd7, 1'b1, 1'b1, 1'b1), 16'h4000);
        send(8'hFF, 16'hFFFF, mk_ctrl(4'd2, 1'b0, 1'b1, 1'b0), 16'hFFFC);
        send(8'h80, 16'hFFFF, mk_ctrl(4'd0, 1'b1, 1'b0, 1'b1), 16'hFF80);
        send(8'h55, 16'hFFFF, mk_ctrl(4'd9, 1'b0, 1'b0, 1'b0), 16'h0055);
        send(8'hC0, 16'hFFFF, mk_ctrl(4'd7, 1'b1, 1'b0, 1'b0), 16'hA000);
        send(8'h7F, 16'hFFFB, mk_ctrl(4'd3, 1'b0, 1'b0, 1'b0), 16'h03F8);
        drain();
        check("stream_sat_seen", 256'(flags.sat_seen), 256'(1'b0));

        // Saturation and wrap on the 8-bit-output instance.
        check("sat8_before", 256'(flags8.sat_seen), 256'(1'b0));
        send8(8'hFF, mk_ctrl(4'd7, 1'b0, 1'b0, 1'b1), 8'hFF);
        drain();
        check("sat8_after_clamp", 256'(flags8.sat_seen), 256'(1'b1));
        send8(8'hFF, mk_ctrl(4'd7, 1'b0, 1'b0, 1'b0), 8'h80);
        drain();
        check("sat8_sticky", 256'(flags8.sat_seen), 256'(1'b1));

        // Backpressure: two accepted, third held off, head stable despite ctrl changes.
        data_o_ready = 1'b0;
        send(8'h7F, 16'hFFFF, mk_ctrl(4'd3, 1'b0, 1'b0, 1'b0), 16'h03F8);
        send(8'h80, 16'hFFFF, mk_ctrl(4'd7, 1'b1, 1'b1, 1'b0), 16'h4000);
        #1;
        check("bp_ready_low", 256'(data_i_ready), 256'(1'b0));
        check("bp_count", 256'(flags.count), 256'(2'd2));
        check("bp_head_shift_sel", 256'(flags.shift_sel), 256'(4'd3));
        head_a = rep_data(16'h03F8, 16'hFFFF);
        data_i_data  = {16{8'h55}};
        data_i_strb  = 16'hFFFF;
        ctrl         = mk_ctrl(4'd9, 1'b0, 1'b0, 1'b0);
        data_i_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("bp_head_stable", data_o_data, head_a);
            check("bp_still_full", 256'(data_i_ready), 256'(1'b0));
        end
        @(negedge clk);
        data_o_ready = 1'b1;
        send(8'h55, 16'hFFFF, mk_ctrl(4'd9, 1'b0, 1'b0, 1'b0), 16'h0055);
        drain();

        // Clear with a full FIFO and an offered beat.
        data_o_ready = 1'b0;
        send(8'h01, 16'hFFFF, mk_ctrl(4'd0, 1'b0, 1'b0, 1'b0), 16'h0001);
        send(8'h02, 16'hFFFF, mk_ctrl(4'd0, 1'b0, 1'b0, 1'b0), 16'h0002);
        data_i_data  = {16{8'h03}};
        data_i_valid = 1'b1;
        clear_i      = 1'b1;
        @(negedge clk);
        clear_i      = 1'b0;
        data_i_valid = 1'b0;
        #1;
        check("clr_count", 256'(flags.count), 256'(2'd0));
        check("clr_valid", 256'(data_o_valid), 256'(1'b0));
        check("clr_sat8", 256'(flags8.sat_seen), 256'(1'b0));
        sb.delete();
        @(negedge clk);

        // Clear while space is available: the simultaneous push must be dropped.
        send(8'h04, 16'hFFFF, mk_ctrl(4'd0, 1'b0, 1'b0, 1'b0), 16'h0004);
        data_i_data  = {16{8'h05}};
        data_i_valid = 1'b1;
        clear_i      = 1'b1;
        @(negedge clk);
        clear_i      = 1'b0;
        data_i_valid = 1'b0;
        #1;
        check("clr1_count", 256'(flags.count), 256'(2'd0));
        sb.delete();
        @(negedge clk);
        data_o_ready = 1'b1;
        send(8'h06, 16'hFFFF, mk_ctrl(4'd1, 1'b0, 1'b0, 1'b0), 16'h000C);
        drain();

        // Reset mid-stream drops buffered beats and the sticky flag.
        send8(8'hFF, mk_ctrl(4'd7, 1'b0, 1'b0, 1'b1), 8'hFF);
        drain();
        check("sat8_reset_pre", 256'(flags8.sat_seen), 256'(1'b1));
        data_o_ready = 1'b0;
        send(8'h11, 16'hFFFF, mk_ctrl(4'd0, 1'b0, 1'b0, 1'b0), 16'h0011);
        send(8'h22, 16'hFFFF, mk_ctrl(4'd0, 1'b0, 1'b0, 1'b0), 16'h0022);
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        check("midrst_valid", 256'(data_o_valid), 256'(1'b0));
        check("midrst_ready", 256'(data_i_ready), 256'(1'b1));
        check("midrst_count", 256'(flags.count), 256'(2'd0));
        check("midrst_sat8", 256'(flags8.sat_seen), 256'(1'b0));
        sb.delete();
        @(negedge clk);
        data_o_ready = 1'b1;
        send(8'h33, 16'hFFFF, mk_ctrl(4'd4, 1'b0, 1'b1, 1'b0), 16'h0330);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
